// File: rtl/pcie_rx_tlp_dispatch_if.sv
// rtl/pcie_rx_tlp_dispatch_if.sv - bus bundle for the RX TLP dispatcher
//
// Purpose: groups the dispatcher's input TLP stream, write port, read-request
// queue, completion port and status outputs into one interface.
// Parameter: ADDR_W - width of wr_addr / rd_req_addr.
// Modports:
//   master - upstream/downstream side: drives hdr, data, sof, bar_hit,
//            rd_req_ready; observes every dispatcher output.
//   slave  - the dispatcher itself.
interface pcie_rx_tlp_dispatch_if #(
  parameter int ADDR_W = 32
);
  logic [127:0]      hdr;
  logic [127:0]      data;
  logic              sof;
  logic [7:0]        bar_hit;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [127:0]      wr_data;
  logic [15:0]       wr_be;
  logic [2:0]        wr_bar;

  logic              rd_req_valid;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr;
  logic [9:0]        rd_req_len;
  logic [7:0]        rd_req_tag;
  logic [15:0]       rd_req_rid;
  logic [7:0]        rd_req_be;
  logic [2:0]        rd_req_bar;

  logic              cpl_valid;
  logic [127:0]      cpl_data;
  logic [7:0]        cpl_tag;
  logic              cpl_last;

  logic [15:0]       drop_cnt;
  logic              rd_ovf;
  logic              err_seq;

  modport master (
    output hdr, data, sof, bar_hit, rd_req_ready,
    input  wr_en, wr_addr, wr_data, wr_be, wr_bar,
    input  rd_req_valid, rd_req_addr, rd_req_len, rd_req_tag, rd_req_rid,
    input  rd_req_be, rd_req_bar,
    input  cpl_valid, cpl_data, cpl_tag, cpl_last,
    input  drop_cnt, rd_ovf, err_seq
  );

  modport slave (
    input  hdr, data, sof, bar_hit, rd_req_ready,
    output wr_en, wr_addr, wr_data, wr_be, wr_bar,
    output rd_req_valid, rd_req_addr, rd_req_len, rd_req_tag, rd_req_rid,
    output rd_req_be, rd_req_bar,
    output cpl_valid, cpl_data, cpl_tag, cpl_last,
    output drop_cnt, rd_ovf, err_seq
  );
endinterface

// File: rtl/pcie_rx_tlp_dispatch.sv
// rtl/pcie_rx_tlp_dispatch.sv - receive-side PCIe TLP dispatcher
//
// Purpose: decodes each normalized TLP header at sof and routes it: MWr payload
// to a registered write port, MRd to a first-word-fall-through request FIFO,
// CplD payload to a completion port. Counts dropped TLPs (saturating), flags
// read-queue overflow and sof arriving mid-payload (both sticky).
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   bus     - pcie_rx_tlp_dispatch_if.slave (hdr/data/sof/bar_hit in,
//             wr_*, rd_req_*, cpl_*, drop_cnt/rd_ovf/err_seq out,
//             rd_req_ready in)
// Parameters: ADDR_W (address width), RDQ_DEPTH (read FIFO depth, 2^n >= 2).
// Build option: PCIE_RX_CPLD_FWD_EN - when defined, CplD is forwarded to
// cpl_*; otherwise cpl_* are tied to 0 and CplD is dropped as unsupported.
module pcie_rx_tlp_dispatch #(
  parameter int ADDR_W    = 32,
  parameter int RDQ_DEPTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  pcie_rx_tlp_dispatch_if.slave bus
);
  localparam int PW = (RDQ_DEPTH > 1) ? $clog2(RDQ_DEPTH) : 1;

`ifdef PCIE_RX_CPLD_FWD_EN
  typedef enum logic [1:0] {S_IDLE, S_WR_DATA, S_CPL_DATA, S_DROP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WR_DATA, S_DROP} state_t;
`endif

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [9:0]        len;
    logic [7:0]        tag;
    logic [15:0]       rid;
    logic [7:0]        be;
    logic [2:0]        bar;
  } rdq_entry_t;

  // ---------------- header decode ----------------
  logic [1:0]        w_fmt;
  logic [4:0]        w_type;
  logic [9:0]        w_len_raw;
  logic [10:0]       w_len_dw;
  logic [8:0]        w_beats;
  logic [63:0]       w_addr64;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_bar;
  logic              w_bar_any;
  logic              w_is_mwr;
  logic              w_is_mrd;
  logic              w_unused;

  assign w_fmt     = bus.hdr[30:29];
  assign w_type    = bus.hdr[28:24];
  assign w_len_raw = bus.hdr[9:0];
  assign w_len_dw  = (w_len_raw == 10'd0) ? 11'd1024 : {1'b0, w_len_raw};
  assign w_beats   = 9'((w_len_dw + 11'd3) >> 2);
  assign w_bar_any = (bus.bar_hit != 8'd0);
  assign w_is_mwr  = w_fmt[1] && (w_type == 5'd0) && w_bar_any;
  assign w_is_mrd  = bus.sof && !w_fmt[1] && (w_type == 5'd0) && w_bar_any;

  // A zero upper DW means a 32-bit address sits in DW2; otherwise DW2 holds
  // the high half and DW3 the low half of a 64-bit address.
  always_comb begin
    w_addr64 = (bus.hdr[127:96] == 32'd0) ? {32'd0, bus.hdr[95:64]}
                                          : {bus.hdr[95:64], bus.hdr[127:96]};
    w_addr64[1:0] = 2'b00;
  end
  assign w_addr   = w_addr64[ADDR_W-1:0];
  assign w_unused = ^w_addr64;

  // Lowest set bit wins: later (lower-index) assignments override.
  always_comb begin
    w_bar = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.bar_hit[i]) w_bar = 3'(i);
    end
  end

`ifdef PCIE_RX_CPLD_FWD_EN
  logic w_is_cpld;
  assign w_is_cpld = (w_fmt == 2'b10) && (w_type == 5'b01010);
`endif

  // ---------------- read-request FIFO ----------------
  rdq_entry_t     r_q_mem [RDQ_DEPTH];
  logic [PW-1:0]  r_q_wp;
  logic [PW-1:0]  r_q_rp;
  logic [PW:0]    r_q_cnt;
  logic           w_q_full;
  logic           w_pop;
  logic           w_push;
  rdq_entry_t     w_q_in;
  rdq_entry_t     w_q_head;

  assign w_q_full = (r_q_cnt == (PW+1)'(RDQ_DEPTH));
  assign w_pop    = (r_q_cnt != '0) && bus.rd_req_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO succeeds.
  assign w_push   = w_is_mrd && (!w_q_full || w_pop);

  assign w_q_in.addr = w_addr;
  assign w_q_in.len  = w_len_raw;
  assign w_q_in.tag  = bus.hdr[47:40];
  assign w_q_in.rid  = bus.hdr[63:48];
  assign w_q_in.be   = bus.hdr[39:32];
  assign w_q_in.bar  = w_bar;

  always_ff @(posedge clk) begin
    if (w_push) r_q_mem[r_q_wp] <= w_q_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q_wp  <= '0;
      r_q_rp  <= '0;
      r_q_cnt <= '0;
    end else begin
      if (w_push) r_q_wp <= r_q_wp + 1'b1;
      if (w_pop)  r_q_rp <= r_q_rp + 1'b1;
      r_q_cnt <= r_q_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
    end
  end

  // Head is zeroed while empty so outputs read 0 out of reset.
  assign w_q_head = (r_q_cnt != '0) ? r_q_mem[r_q_rp] : '0;

  assign bus.rd_req_valid = (r_q_cnt != '0);
  assign bus.rd_req_addr  = w_q_head.addr;
  assign bus.rd_req_len   = w_q_head.len;
  assign bus.rd_req_tag   = w_q_head.tag;
  assign bus.rd_req_rid   = w_q_head.rid;
  assign bus.rd_req_be    = w_q_head.be;
  assign bus.rd_req_bar   = w_q_head.bar;

  // ---------------- payload FSM ----------------
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [10:0]       r_len_dw;
  logic [3:0]        r_fbe;
  logic [3:0]        r_lbe;
  logic [2:0]        r_bar;
  logic [8:0]        r_beats_left;
  logic [7:0]        r_beat_k;

  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [127:0]      r_wr_data;
  logic [15:0]       r_wr_be;
  logic [2:0]        r_wr_bar;
  logic [15:0]       r_drop_cnt;
  logic              r_rd_ovf;
  logic              r_err_seq;

`ifdef PCIE_RX_CPLD_FWD_EN
  logic [7:0]        r_hdr_tag;
  logic              r_cpl_valid;
  logic [127:0]      r_cpl_data;
  logic [7:0]        r_cpl_tag;
  logic              r_cpl_last;
`endif

  // Byte enables for the current beat: payload DW index is 4k+i.
  logic [15:0] w_be;
  always_comb begin
    w_be = 16'h0;
    for (int i = 0; i < 4; i++) begin
      if ({1'b0, r_beat_k, 2'(i)} >= r_len_dw)
        w_be[4*i +: 4] = 4'h0;
      else if ({r_beat_k, 2'(i)} == 10'd0)
        w_be[4*i +: 4] = r_fbe;
      else if ({1'b0, r_beat_k, 2'(i)} == r_len_dw - 11'd1)
        w_be[4*i +: 4] = r_lbe;
      else
        w_be[4*i +: 4] = 4'hF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_len_dw     <= '0;
      r_fbe        <= '0;
      r_lbe        <= '0;
      r_bar        <= '0;
      r_beats_left <= '0;
      r_beat_k     <= '0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_wr_be      <= '0;
      r_wr_bar     <= '0;
      r_drop_cnt   <= '0;
      r_rd_ovf     <= 1'b0;
      r_err_seq    <= 1'b0;
`ifdef PCIE_RX_CPLD_FWD_EN
      r_hdr_tag    <= '0;
      r_cpl_valid  <= 1'b0;
      r_cpl_data   <= '0;
      r_cpl_tag    <= '0;
      r_cpl_last   <= 1'b0;
`endif
    end else begin
      r_wr_en <= 1'b0;
`ifdef PCIE_RX_CPLD_FWD_EN
      r_cpl_valid <= 1'b0;
      r_cpl_last  <= 1'b0;
`endif
      if (r_state != S_IDLE) begin
        if (bus.sof && (r_beats_left != 9'd1)) begin
          // Early sof: abandon the packet, this cycle's data is not a beat.
          r_err_seq <= 1'b1;
          r_state   <= S_IDLE;
        end else begin
          case (r_state)
            S_WR_DATA: begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_addr + (ADDR_W'(r_beat_k) << 4);
              r_wr_data <= bus.data;
              r_wr_be   <= w_be;
              r_wr_bar  <= r_bar;
            end
`ifdef PCIE_RX_CPLD_FWD_EN
            S_CPL_DATA: begin
              r_cpl_valid <= 1'b1;
              r_cpl_data  <= bus.data;
              r_cpl_tag   <= r_hdr_tag;
              r_cpl_last  <= (r_beats_left == 9'd1);
            end
`endif
            default: ;
          endcase
          r_beats_left <= r_beats_left - 9'd1;
          r_beat_k     <= r_beat_k + 8'd1;
          if (r_beats_left == 9'd1) r_state <= S_IDLE;
        end
      end

      // New header decode overrides any state update from the final beat.
      if (bus.sof) begin
        r_addr       <= w_addr;
        r_len_dw     <= w_len_dw;
        r_fbe        <= bus.hdr[35:32];
        r_lbe        <= bus.hdr[39:36];
        r_bar        <= w_bar;
        r_beats_left <= w_beats;
        r_beat_k     <= 8'd0;
`ifdef PCIE_RX_CPLD_FWD_EN
        r_hdr_tag    <= bus.hdr[79:72];
`endif
        if (w_is_mwr) begin
          r_state <= S_WR_DATA;
        end else if (w_is_mrd) begin
          r_state <= S_IDLE;
          if (!w_push) begin
            r_rd_ovf <= 1'b1;
            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
          end
`ifdef PCIE_RX_CPLD_FWD_EN
        end else if (w_is_cpld) begin
          r_state <= S_CPL_DATA;
`endif
        end else begin
          r_state <= w_fmt[1] ? S_DROP : S_IDLE;
          if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;
  assign bus.wr_be    = r_wr_be;
  assign bus.wr_bar   = r_wr_bar;
  assign bus.drop_cnt = r_drop_cnt;
  assign bus.rd_ovf   = r_rd_ovf;
  assign bus.err_seq  = r_err_seq;

`ifdef PCIE_RX_CPLD_FWD_EN
  assign bus.cpl_valid = r_cpl_valid;
  assign bus.cpl_data  = r_cpl_data;
  assign bus.cpl_tag   = r_cpl_tag;
  assign bus.cpl_last  = r_cpl_last;
`else
  assign bus.cpl_valid = 1'b0;
  assign bus.cpl_data  = '0;
  assign bus.cpl_tag   = '0;
  assign bus.cpl_last  = 1'b0;
`endif
endmodule

// File: tb/tb_pcie_rx_tlp_dispatch.sv
// tb/tb_pcie_rx_tlp_dispatch.sv - directed self-checking bench for pcie_rx_tlp_dispatch
module tb_pcie_rx_tlp_dispatch;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pcie_rx_tlp_dispatch_if #(.ADDR_W(32)) bus ();

  pcie_rx_tlp_dispatch #(.ADDR_W(32), .RDQ_DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

`ifdef PCIE_RX_CPLD_FWD_EN
  localparam bit CPL_EN = 1'b1;
`else
  localparam bit CPL_EN = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;
  int exp_drop = 0;

  task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk_hdr(input logic [1:0] fmt, input logic [4:0] typ,
                                          input logic [9:0] len, input logic [3:0] fbe,
                                          input logic [3:0] lbe, input logic [15:0] rid,
                                          input logic [7:0] tag, input logic [31:0] dw2,
                                          input logic [31:0] dw3);
    logic [127:0] h;
    h = '0;
    h[30:29]  = fmt;
    h[28:24]  = typ;
    h[9:0]    = len;
    h[35:32]  = fbe;
    h[39:36]  = lbe;
    h[47:40]  = tag;
    h[63:48]  = rid;
    h[95:64]  = dw2;
    h[127:96] = dw3;
    return h;
  endfunction

  task automatic put_sof(input logic [127:0] h, input logic [7:0] bar);
    bus.sof     = 1'b1;
    bus.hdr     = h;
    bus.bar_hit = bar;
  endtask

  task automatic put_beat(input logic [127:0] d);
    bus.sof  = 1'b0;
    bus.data = d;
  endtask

  initial begin
    rst = 1'b1;
    bus.sof = 1'b0;
    bus.hdr = '0;
    bus.data = '0;
    bus.bar_hit = '0;
    bus.rd_req_ready = 1'b0;
    tick();
    tick();

    // reset state
    check_vec("rst_wr_en", bus.wr_en, 0);
    check_vec("rst_wr_addr", bus.wr_addr, 0);
    check_vec("rst_rd_valid", bus.rd_req_valid, 0);
    check_vec("rst_drop", bus.drop_cnt, 0);
    check_vec("rst_ovf", bus.rd_ovf, 0);
    check_vec("rst_err", bus.err_seq, 0);
    check_vec("rst_cpl_valid", bus.cpl_valid, 0);
    rst = 1'b0;
    tick();

    // MWr len=6 @0x1000, be F/3, bar 0x02
    put_sof(mk_hdr(2'b10, 5'd0, 10'd6, 4'hF, 4'h3, 16'h0, 8'h0, 32'h1000, 32'h0), 8'h02);
    tick();
    check_vec("mwr6_no_early", bus.wr_en, 0);
    put_beat(128'hA0A0_0003_A0A0_0002_A0A0_0001_A0A0_0000);
    tick();
    check_vec("mwr6_b0_en", bus.wr_en, 1);
    check_vec("mwr6_b0_addr", bus.wr_addr, 32'h1000);
    check_vec("mwr6_b0_be", bus.wr_be, 16'hFFFF);
    check_vec("mwr6_b0_data", bus.wr_data, 128'hA0A0_0003_A0A0_0002_A0A0_0001_A0A0_0000);
    check_vec("mwr6_b0_bar", bus.wr_bar, 3'd1);
    put_beat(128'hB1B1_0007_B1B1_0006_B1B1_0005_B1B1_0004);
    tick();
    check_vec("mwr6_b1_en", bus.wr_en, 1);
    check_vec("mwr6_b1_addr", bus.wr_addr, 32'h1010);
    check_vec("mwr6_b1_be", bus.wr_be, 16'h003F);
    check_vec("mwr6_b1_bar", bus.wr_bar, 3'd1);
    put_beat('0);
    tick();
    check_vec("mwr6_done", bus.wr_en, 0);

    // MWr len=1 be 6, MRd sof on its only beat (64-bit address form)
    put_sof(mk_hdr(2'b10, 5'd0, 10'd1, 4'h6, 4'h0, 16'h0, 8'h0, 32'h2000, 32'h0), 8'h01);
    tick();
    put_sof(mk_hdr(2'b01, 5'd0, 10'd4, 4'hF, 4'hF, 16'hBEEF, 8'h11, 32'h1, 32'h3003), 8'h04);
    bus.data = 128'h1234;
    tick();
    bus.sof = 1'b0;
    check_vec("mwr1_en", bus.wr_en, 1);
    check_vec("mwr1_addr", bus.wr_addr, 32'h2000);
    check_vec("mwr1_be", bus.wr_be, 16'h0006);
    check_vec("mwr1_bar", bus.wr_bar, 3'd0);
    check_vec("mrd_valid", bus.rd_req_valid, 1);
    check_vec("mrd_addr", bus.rd_req_addr, 32'h3000);
    check_vec("mrd_tag", bus.rd_req_tag, 8'h11);
    check_vec("mrd_rid", bus.rd_req_rid, 16'hBEEF);
    check_vec("mrd_len", bus.rd_req_len, 10'd4);
    check_vec("mrd_be", bus.rd_req_be, 8'hFF);
    check_vec("mrd_bar", bus.rd_req_bar, 3'd2);
    check_vec("mrd_err_seq", bus.err_seq, 0);
    tick();
    check_vec("mwr1_single", bus.wr_en, 0);
    bus.rd_req_ready = 1'b1;
    tick();
    bus.rd_req_ready = 1'b0;
    check_vec("mrd_popped", bus.rd_req_valid, 0);

    // 9 MRds into an 8-deep queue with ready low
    for (int i = 0; i < 9; i++) begin
      put_sof(mk_hdr(2'b00, 5'd0, 10'd1, 4'hF, 4'h0, 16'h0100, 8'(i), 32'h4000 + 32'(i) * 16, 32'h0), 8'h01);
      tick();
    end
    bus.sof = 1'b0;
    exp_drop++;
    check_vec("ovf_valid", bus.rd_req_valid, 1);
    check_vec("ovf_flag", bus.rd_ovf, 1);
    check_vec("ovf_drop", bus.drop_cnt, 16'(exp_drop));
    tick();
    check_vec("ovf_hold_tag", bus.rd_req_tag, 8'h00);
    check_vec("ovf_hold_addr", bus.rd_req_addr, 32'h4000);
    // push while full with a coincident pop
    bus.rd_req_ready = 1'b1;
    put_sof(mk_hdr(2'b00, 5'd0, 10'd1, 4'hF, 4'h0, 16'h0100, 8'h99, 32'h9990, 32'h0), 8'h01);
    tick();
    bus.sof = 1'b0;
    for (int i = 1; i < 8; i++) begin
      check_vec("fifo_order_tag", bus.rd_req_tag, 8'(i));
      check_vec("fifo_order_addr", bus.rd_req_addr, 32'h4000 + 32'(i) * 16);
      tick();
    end
    check_vec("fifo_fullpush_tag", bus.rd_req_tag, 8'h99);
    check_vec("fifo_fullpush_addr", bus.rd_req_addr, 32'h9990);
    tick();
    bus.rd_req_ready = 1'b0;
    check_vec("fifo_empty", bus.rd_req_valid, 0);
    check_vec("fifo_drop_same", bus.drop_cnt, 16'(exp_drop));

    // CplD len=8 tag 0x2A
    put_sof(mk_hdr(2'b10, 5'b01010, 10'd8, 4'h0, 4'h0, 16'h0, 8'h0, 32'h0000_2A00, 32'h0), 8'h00);
    tick();
    put_beat(128'hC0);
    tick();
    check_vec("cpl_b0_valid", bus.cpl_valid, CPL_EN);
    check_vec("cpl_b0_last", bus.cpl_last, 0);
    check_vec("cpl_b0_tag", bus.cpl_tag, CPL_EN ? 8'h2A : 8'h00);
    check_vec("cpl_b0_data", bus.cpl_data, CPL_EN ? 128'hC0 : 128'h0);
    put_beat(128'hC1);
    tick();
    check_vec("cpl_b1_valid", bus.cpl_valid, CPL_EN);
    check_vec("cpl_b1_last", bus.cpl_last, CPL_EN);
    put_beat('0);
    tick();
    check_vec("cpl_done", bus.cpl_valid, 0);
    check_vec("cpl_no_wr", bus.wr_en, 0);
    if (!CPL_EN) exp_drop++;
    check_vec("cpl_drop", bus.drop_cnt, 16'(exp_drop));

    // unsupported TLP without payload (config read)
    put_sof(mk_hdr(2'b00, 5'b00100, 10'd1, 4'hF, 4'h0, 16'h0, 8'h0, 32'h0, 32'h0), 8'h01);
    tick();
    bus.sof = 1'b0;
    exp_drop++;
    check_vec("cfg_drop", bus.drop_cnt, 16'(exp_drop));
    check_vec("cfg_no_rdq", bus.rd_req_valid, 0);

    // MWr len=12 interrupted after its first beat
    put_sof(mk_hdr(2'b10, 5'd0, 10'd12, 4'hF, 4'hF, 16'h0, 8'h0, 32'h5000, 32'h0), 8'h01);
    tick();
    put_beat(128'h50);
    tick();
    check_vec("abort_b0_en", bus.wr_en, 1);
    check_vec("abort_b0_addr", bus.wr_addr, 32'h5000);
    put_sof(mk_hdr(2'b10, 5'd0, 10'd4, 4'hF, 4'hF, 16'h0, 8'h0, 32'h6000, 32'h0), 8'h80);
    bus.data = 128'h51;
    tick();
    check_vec("abort_no_strobe", bus.wr_en, 0);
    check_vec("abort_err_seq", bus.err_seq, 1);
    put_beat(128'h60);
    tick();
    check_vec("after_abort_en", bus.wr_en, 1);
    check_vec("after_abort_addr", bus.wr_addr, 32'h6000);
    check_vec("after_abort_be", bus.wr_be, 16'hFFFF);
    check_vec("after_abort_bar", bus.wr_bar, 3'd7);
    check_vec("after_abort_data", bus.wr_data, 128'h60);
    put_beat('0);
    tick();
    check_vec("after_abort_done", bus.wr_en, 0);

    // reset during a 3-beat MWr
    put_sof(mk_hdr(2'b10, 5'd0, 10'd10, 4'hF, 4'hF, 16'h0, 8'h0, 32'h7000, 32'h0), 8'h01);
    tick();
    put_beat(128'h70);
    tick();
    check_vec("rstmid_b0_en", bus.wr_en, 1);
    rst = 1'b1;
    bus.data = 128'h71;
    tick();
    check_vec("rstmid_en", bus.wr_en, 0);
    check_vec("rstmid_addr", bus.wr_addr, 0);
    check_vec("rstmid_be", bus.wr_be, 0);
    check_vec("rstmid_data", bus.wr_data, 0);
    check_vec("rstmid_err", bus.err_seq, 0);
    check_vec("rstmid_drop", bus.drop_cnt, 0);
    check_vec("rstmid_ovf", bus.rd_ovf, 0);
    rst = 1'b0;
    bus.data = 128'h72;
    tick();
    check_vec("rstmid_tail_ignored", bus.wr_en, 0);
    put_sof(mk_hdr(2'b10, 5'd0, 10'd1, 4'hF, 4'h0, 16'h0, 8'h0, 32'h8000, 32'h0), 8'h01);
    tick();
    put_beat(128'h80);
    tick();
    check_vec("postrst_en", bus.wr_en, 1);
    check_vec("postrst_addr", bus.wr_addr, 32'h8000);
    check_vec("postrst_be", bus.wr_be, 16'h000F);
    put_beat('0);
    tick();
    check_vec("postrst_done", bus.wr_en, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
